// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r, b_zero;
    logic [WIDTH-1:0]   a_orig, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic               accept_arith, signed_op, last_iter;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in, mul_addend, quot, remd;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] product;

    assign accept_arith = (state == IDLE) && start && !op[2];
    assign signed_op    = !op[0];
    assign last_iter    = (cnt == CW'(WIDTH - 1));
    assign a_mag_in     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag_in     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

    // Multiply: low half of acc holds the remaining multiplier bits, high half the partial product.
    assign mul_addend = acc[0] ? b_mag : '0;
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    // Divide: low half of acc shifts dividend bits out and quotient bits in.
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};

    assign product = neg_q ? -acc : acc;
    assign quot    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign remd    = neg_r ? -rem : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept_arith) state_nx = CALC;
            CALC:    if (last_iter)    state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; all registers here are small, so all are reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            a_orig   <= '0;
            b_mag    <= '0;
            acc      <= '0;
            rem      <= '0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state == FIX);
            if (accept_arith) begin
                is_div   <= op[1];
                neg_q    <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r    <= signed_op && src_a[WIDTH-1];
                b_zero   <= (src_b == '0);
                a_orig   <= src_a;
                b_mag    <= b_mag_in;
                acc      <= {{WIDTH{1'b0}}, a_mag_in};
                rem      <= '0;
                cnt      <= '0;
                div_zero <= 1'b0;
            end else if (state == IDLE && start && op == 3'b100) begin
                hi <= src_a;
            end else if (state == IDLE && start && op == 3'b101) begin
                lo <= src_a;
            end else if (state == CALC) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], !div_diff[WIDTH]};
                    rem <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                end else begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                end
            end else if (state == FIX) begin
                if (!is_div) begin
                    {hi, lo} <= product;
                end else if (b_zero) begin
                    hi       <= a_orig;
                    lo       <= '1;
                    div_zero <= 1'b1;
                end else begin
                    hi <= remd;
                    lo <= quot;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: transaction-level model plus directed vectors
// with hand-computed literal results, and an 8-bit instance for the narrow-width case.
module tb_mdu_iter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [W-1:0]  src_a = '0, src_b = '0;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi, lo;

    logic          start8 = 1'b0;
    logic [2:0]    op8 = '0;
    logic [7:0]    a8 = '0, b8 = '0;
    logic          busy8, done8, dz8;
    logic [7:0]    hi8, lo8;

    int total = 0;
    int bad   = 0;
    logic cmp_en = 1'b0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural result {div_zero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, q, r;
        p = '0; sa = 0; sb = 0; q = 0; r = 0;
        case (o)
            3'b000: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                return {1'b0, p};
            end
            3'b001: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 3'b010) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'b0, a});
                    sb = longint'({32'b0, b});
                end
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Transaction model: an accepted arithmetic op keeps busy for W+1 cycles,
    // then results land together with a one-cycle done.
    int           m_left;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         m_dz, p_dz, m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_hi <= '0; m_lo <= '0; m_dz <= 1'b0; m_done <= 1'b0;
            p_hi <= '0; p_lo <= '0; p_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi <= p_hi; m_lo <= p_lo; m_dz <= p_dz; m_done <= 1'b1;
                end
            end else if (start) begin
                if (op < 3'd4) begin
                    {p_dz, p_hi, p_lo} <= model_op(op, src_a, src_b);
                    m_left <= W + 1;
                    m_dz   <= 1'b0;
                end else if (op == 3'b100) begin
                    m_hi <= src_a;
                end else if (op == 3'b101) begin
                    m_lo <= src_a;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_busy", busy, m_left > 0);
            check("cmp_done", done, m_done);
            check("cmp_div_zero", div_zero, m_dz);
            check("cmp_hi", hi, m_hi);
            check("cmp_lo", lo, m_lo);
        end
    end

    // Callers are positioned just after a falling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        int guard;
        guard = 0;
        cycles = 0;
        while (done !== 1'b1 && guard < 200) begin
            if (busy) cycles++;
            @(negedge clk);
            guard++;
        end
        check("done_within_bound", guard < 200, 1'b1);
    endtask

    initial begin
        int cyc;
        int guard8;
        cyc = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        issue(3'b000, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc);
        check("mult_busy_cycles", cyc, 33);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
        @(negedge clk);
        check("done_single_pulse", done, 0);

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        issue(3'b000, 32'd0, 32'd7);
        check("b2b_accepted", busy, 1);
        wait_done(cyc);
        check("b2b_busy_cycles", cyc, 33);
        check("b2b_hi", hi, 0);
        check("b2b_lo", lo, 0);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 0);

        issue(3'b011, 32'h0000_1234, 32'd0);
        wait_done(cyc);
        check("divz_cycles", cyc, 33);
        check("divz_hi", hi, 32'h0000_1234);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_flag", div_zero, 1);
        issue(3'b001, 32'd3, 32'd4);
        check("divz_cleared", div_zero, 0);
        wait_done(cyc);
        check("multu_small_lo", lo, 32'd12);

        issue(3'b100, 32'hAAAA_5555, 32'd0);
        check("mthi_hi", hi, 32'hAAAA_5555);
        check("mthi_not_busy", busy, 0);
        issue(3'b101, 32'h0F0F_0F0F, 32'd0);
        check("mtlo_lo", lo, 32'h0F0F_0F0F);
        check("mtlo_not_busy", busy, 0);
        issue(3'b011, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        issue(3'b101, 32'hDEAD_BEEF, 32'd0);
        check("ignored_mtlo_lo", lo, 32'h0F0F_0F0F);
        check("busy_holds_hi", hi, 32'hAAAA_5555);
        wait_done(cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(3'b000, 32'd6, 32'd7);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_div_zero", div_zero, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        issue(3'b010, 32'd100, 32'd7);
        wait_done(cyc);
        check("div_after_rst_lo", lo, 32'd14);
        check("div_after_rst_hi", hi, 32'd2);

        start8 = 1'b1; op8 = 3'b010; a8 = 8'd100; b8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        guard8 = 0;
        while (done8 !== 1'b1 && guard8 < 50) begin
            if (busy8) cyc++;
            @(negedge clk);
            guard8++;
        end
        check("w8_done_within_bound", guard8 < 50, 1'b1);
        check("w8_busy_cycles", cyc, 9);
        check("w8_lo", lo8, 8'd14);
        check("w8_hi", hi8, 8'd2);
        check("w8_div_zero", dz8, 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
